// File: rtl/ps2_kbd.sv
// ps2_kbd: PS/2 keyboard receiver with a scan-code FIFO behind a Wishbone slave.
// Conditioned clock/data lines feed an 11-bit frame deserializer; good bytes are queued.
`timescale 1ns/1ps
module ps2_kbd #(
    parameter int CLKFREQ    = 10000000,
    parameter int FILTER     = 8,
    parameter int TIMEOUT    = CLKFREQ / 5000,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [3:0]  bus_adr,
    input  logic [3:0]  bus_sel,
    input  logic [31:0] bus_dat_w,
    output logic [31:0] bus_dat_r,
    output logic        bus_ack,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        interrupt
);
    localparam int FW    = $clog2(FILTER + 1);
    localparam int WW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] clk_cnt, dat_cnt;
    logic          clk_filt, dat_filt, clk_prev;
    logic          strobe;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [WW-1:0] wdog;
    logic          rx_push, rx_perr, rx_ferr;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  valid, full, pop, do_push, ovf_set;
    logic                  access, wr_stat, ie_next;
    logic                  ovf, perr, ferr, ie, busy;
    logic [31:0]           data_word, stat_word;
    logic                  unused_bits;

    // Lines idle high; the filter only follows FILTER matching samples in a row.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_cnt  <= '0;
            dat_cnt  <= '0;
            clk_filt <= 1'b1;
            dat_filt <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (dat_sync[1] == dat_filt) begin
                dat_cnt <= '0;
            end else if (dat_cnt == FW'(FILTER - 1)) begin
                dat_filt <= dat_sync[1];
                dat_cnt  <= '0;
            end else begin
                dat_cnt <= dat_cnt + 1'b1;
            end
        end
    end

    assign strobe = clk_prev & ~clk_filt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            wdog    <= '0;
            rx_push <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            if (state == IDLE || strobe) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
            if (state != IDLE && wdog == WW'(TIMEOUT)) begin
                state   <= IDLE;
                rx_ferr <= 1'b1;
            end else if (strobe) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_filt;
                        state   <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        rx_ferr <= ~dat_filt;
                        rx_perr <= ~^{shreg, par_bit};
                        rx_push <= dat_filt & ^{shreg, par_bit};
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy       = state != IDLE;
    assign access     = bus_cyc & bus_stb & ~bus_ack;
    assign valid      = count != '0;
    assign full       = count == CW'(DEPTH);
    assign pop        = access & ~bus_we & ~bus_adr[2] & valid & bus_sel[0];
    assign wr_stat    = access & bus_we & bus_adr[2];
    assign do_push    = rx_push & (~full | pop);
    assign ovf_set    = rx_push & full & ~pop;
    assign count_next = count + CW'(do_push) - CW'(pop);
    assign ie_next    = wr_stat ? bus_dat_w[16] : ie;

    assign data_word = valid ? {23'b0, 1'b1, mem[rd_ptr]} : 32'b0;
    assign stat_word = 32'(count)
                     | {7'b0, busy, 7'b0, ie, 5'b0, ferr, perr, ovf, 8'b0};

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // Error bits: a set event in the same cycle as a W1C wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_ack   <= 1'b0;
            bus_dat_r <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            ie        <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            bus_ack   <= access;
            bus_dat_r <= '0;
            if (access && !bus_we) begin
                bus_dat_r <= bus_adr[2] ? stat_word : data_word;
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            ovf       <= (ovf  & ~(wr_stat & bus_dat_w[8]))  | ovf_set;
            perr      <= (perr & ~(wr_stat & bus_dat_w[9]))  | rx_perr;
            ferr      <= (ferr & ~(wr_stat & bus_dat_w[10])) | rx_ferr;
            ie        <= ie_next;
            interrupt <= ie_next & (count_next != '0);
        end
    end

    assign unused_bits = ^{bus_adr[3], bus_adr[1:0], bus_sel[3:1],
                           bus_dat_w[31:17], bus_dat_w[15:11], bus_dat_w[7:0]};
endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: PS/2 frames in, Wishbone register reads out.
`timescale 1ns/1ps
module tb_ps2_kbd;
    localparam int FILTER = 8;
    localparam int FAST   = 40;
    localparam int SLOW   = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_cyc = 1'b0;
    logic        bus_stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_adr = '0;
    logic [3:0]  bus_sel = '0;
    logic [31:0] bus_dat_w = '0;
    logic [31:0] bus_dat_r;
    logic        bus_ack;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        interrupt;

    int checks = 0;
    int failures = 0;

    ps2_kbd #(.FILTER(FILTER)) dut (
        .clk_i(clk), .rst_i(rst),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_adr(bus_adr), .bus_sel(bus_sel), .bus_dat_w(bus_dat_w),
        .bus_dat_r(bus_dat_r), .bus_ack(bus_ack),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .interrupt(interrupt)
    );

    always #50 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_access(input logic we, input logic [3:0] adr,
                              input logic [3:0] sel, input logic [31:0] wd,
                              output logic [31:0] rd);
        int n;
        bus_cyc = 1'b1; bus_stb = 1'b1; bus_we = we;
        bus_adr = adr; bus_sel = sel; bus_dat_w = wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus_ack && n < 8);
        check("ack_rise", 32'(bus_ack), 32'd1);
        rd = bus_dat_r;
        bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
        cyc(1);
        check("ack_pulse", 32'(bus_ack), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] adr,
                          input logic [3:0] sel, input logic [31:0] exp);
        logic [31:0] d;
        bus_access(1'b0, adr, sel, 32'd0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
        logic [31:0] d;
        bus_access(1'b1, adr, 4'hF, wd, d);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input int half,
                             input logic glitch, input logic irq_chk);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                cyc(half / 2);
                ps2_data = ~f[i];
                cyc(3);
                ps2_data = f[i];
                cyc(half - half / 2 - 3);
            end else begin
                cyc(half);
            end
            ps2_clk = 1'b0;
            if (irq_chk && i == n - 1) begin
                cyc(FILTER + 4);
                check("irq_rise", 32'(interrupt), 32'd1);
                cyc(half - FILTER - 4);
            end else begin
                cyc(half);
            end
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input int half, input logic glitch,
                              input logic irq_chk);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11, half, glitch, irq_chk);
        cyc(half);
    endtask

    initial begin
        cyc(3);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_dat", bus_dat_r, 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        rst = 1'b0;
        cyc(2);
        rd_chk("rst_status", 4'h4, 4'hF, 32'h0000_0000);
        rd_chk("rst_data", 4'h0, 4'hF, 32'h0000_0000);

        send_frame(8'h1C, 1'b0, SLOW, 1'b0, 1'b0);
        rd_chk("slow_status", 4'h4, 4'hF, 32'h0000_0001);
        check("slow_irq_off", 32'(interrupt), 32'd0);
        rd_chk("slow_data", 4'h0, 4'hF, 32'h0000_011C);
        rd_chk("slow_empty", 4'h0, 4'hF, 32'h0000_0000);

        wr(4'h4, 32'h0001_0000);
        check("ie_no_irq", 32'(interrupt), 32'd0);
        send_frame(8'h5A, 1'b0, FAST, 1'b0, 1'b1);
        rd_chk("peek", 4'h0, 4'h0, 32'h0000_015A);
        rd_chk("ie_status", 4'h4, 4'hF, 32'h0001_0001);
        check("irq_held", 32'(interrupt), 32'd1);
        rd_chk("irq_data", 4'h0, 4'hF, 32'h0000_015A);
        check("irq_fall", 32'(interrupt), 32'd0);
        wr(4'h4, 32'h0000_0000);

        send_frame(8'h1C, 1'b1, FAST, 1'b0, 1'b0);
        rd_chk("perr_status", 4'h4, 4'hF, 32'h0000_0200);
        wr(4'h4, 32'h0000_0200);
        rd_chk("perr_clear", 4'h4, 4'hF, 32'h0000_0000);

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b0, FAST, 1'b0, 1'b0);
        end
        rd_chk("full_status", 4'h4, 4'hF, 32'h0000_0110);
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("fifo_%0d", i), 4'h0, 4'hF, 32'h100 + 32'(i));
        end
        rd_chk("drain_empty", 4'h0, 4'hF, 32'h0000_0000);
        rd_chk("ovf_sticky", 4'h4, 4'hF, 32'h0000_0100);
        wr(4'h4, 32'h0000_0100);
        rd_chk("ovf_clear", 4'h4, 4'hF, 32'h0000_0000);

        send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 4, FAST, 1'b0, 1'b0);
        rd_chk("busy_status", 4'h4, 4'hF, 32'h0100_0000);
        cyc(2500);
        rd_chk("tmo_status", 4'h4, 4'hF, 32'h0000_0400);
        send_frame(8'hF0, 1'b0, FAST, 1'b0, 1'b0);
        rd_chk("tmo_recover", 4'h4, 4'hF, 32'h0000_0401);
        rd_chk("tmo_data", 4'h0, 4'hF, 32'h0000_01F0);
        wr(4'h4, 32'h0000_0400);
        rd_chk("ferr_clear", 4'h4, 4'hF, 32'h0000_0000);

        ps2_data = 1'b0;
        cyc(20);
        for (int i = 0; i < 3; i++) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(20);
        end
        rd_chk("glitch_idle", 4'h4, 4'hF, 32'h0000_0000);
        ps2_data = 1'b1;
        cyc(20);
        send_frame(8'h3A, 1'b0, FAST, 1'b1, 1'b0);
        rd_chk("glitch_status", 4'h4, 4'hF, 32'h0000_0001);
        rd_chk("glitch_data", 4'h0, 4'hF, 32'h0000_013A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
